// File: rtl/matrix_op_sequencer.sv
// Control sequencer for one matrix instruction: issues per-element read
// addresses, accumulator controls and writebacks over 8 x 4x4 matrices.
module matrix_op_sequencer #(
    parameter logic [2:0] MMUL_DEST = 3'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [2:0] dest,
    input  logic [2:0] src,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       halted,
    output logic       rd_en,
    output logic [6:0] rd_addr_a,
    output logic [6:0] rd_addr_b,
    output logic [2:0] alu_op,
    output logic       acc_clr,
    output logic       acc_en,
    output logic       wr_en,
    output logic [6:0] wr_addr
);
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SCAL = 3'b100;
    localparam logic [2:0] OP_MMUL = 3'b101;
    localparam logic [2:0] OP_TRAN = 3'b110;
    localparam logic [2:0] OP_STOP = 3'b111;

    typedef enum logic [2:0] {IDLE, ELEM, MMUL, DRAIN, FIN} state_t;

    state_t     state, state_nx;
    logic [5:0] cnt;
    logic [2:0] op_q, dest_q, src_q;
    logic       err_q;
    logic       accept, illegal;
    logic [6:0] waddr_iss;

    // vld_pipe[1]: one cycle after issue (element write / acc control);
    // vld_pipe[2]: two cycles after issue (matrix-multiply writeback).
    logic [2:1] vld_pipe;
    logic       mm1;
    logic [1:0] k1;
    logic [6:0] waddr1, waddr2;

    assign accept = (state == IDLE) && start && !halted;

    always_comb begin
        illegal = 1'b0;
        case (op)
            OP_SCAL, OP_TRAN: illegal = (dest == src);
            OP_MMUL:          illegal = (dest == MMUL_DEST) || (src == MMUL_DEST);
            default:          illegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= '0;
            dest_q <= '0;
            src_q  <= '0;
            err_q  <= 1'b0;
            halted <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q   <= op;
                dest_q <= dest;
                src_q  <= src;
                err_q  <= illegal;
                if (op == OP_STOP) halted <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (op == OP_NOP || op == OP_STOP || illegal) state_nx = FIN;
                    else if (op == OP_MMUL)                      state_nx = MMUL;
                    else                                         state_nx = ELEM;
                end
            end
            ELEM:  if (cnt == 6'd15) state_nx = DRAIN;
            MMUL:  if (cnt == 6'd63) state_nx = DRAIN;
            // Multiply needs a second drain cycle for its two-deep writeback.
            DRAIN: if (!(op_q == OP_MMUL && cnt == 6'd0)) state_nx = FIN;
            FIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            case (state)
                ELEM:    cnt <= (cnt == 6'd15) ? 6'd0 : cnt + 6'd1;
                MMUL:    cnt <= cnt + 6'd1;
                DRAIN:   cnt <= (state_nx == DRAIN) ? 6'd1 : 6'd0;
                default: cnt <= '0;
            endcase
        end
    end

    // Element walk uses cnt as {r,c}; multiply walk uses cnt as {i,j,k}.
    always_comb begin
        rd_en     = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        waddr_iss = '0;
        if (state == ELEM) begin
            rd_en     = 1'b1;
            waddr_iss = {dest_q, cnt[3:2], cnt[1:0]};
            case (op_q)
                OP_LOAD: rd_addr_a = {src_q, cnt[3:2], cnt[1:0]};
                OP_TRAN: rd_addr_a = {src_q, cnt[1:0], cnt[3:2]};
                OP_SCAL: begin
                    rd_addr_a = {dest_q, cnt[3:2], cnt[1:0]};
                    rd_addr_b = {src_q, 4'b0000};
                end
                default: begin
                    rd_addr_a = {dest_q, cnt[3:2], cnt[1:0]};
                    rd_addr_b = {src_q, cnt[3:2], cnt[1:0]};
                end
            endcase
        end else if (state == MMUL) begin
            rd_en     = 1'b1;
            rd_addr_a = {dest_q, cnt[5:4], cnt[1:0]};
            rd_addr_b = {src_q, cnt[1:0], cnt[3:2]};
            waddr_iss = {MMUL_DEST, cnt[5:4], cnt[3:2]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            mm1      <= 1'b0;
            k1       <= '0;
            waddr1   <= '0;
            waddr2   <= '0;
        end else begin
            vld_pipe[1] <= rd_en;
            vld_pipe[2] <= vld_pipe[1] && mm1 && (k1 == 2'd3);
            mm1         <= (state == MMUL);
            k1          <= cnt[1:0];
            waddr1      <= waddr_iss;
            waddr2      <= waddr1;
        end
    end

    always_comb begin
        wr_en   = (vld_pipe[1] && !mm1) || vld_pipe[2];
        wr_addr = '0;
        if (vld_pipe[2])               wr_addr = waddr2;
        else if (vld_pipe[1] && !mm1)  wr_addr = waddr1;
        acc_clr = vld_pipe[1] && mm1 && (k1 == 2'd0);
        acc_en  = vld_pipe[1] && mm1 && (k1 != 2'd0);
        busy    = (state == ELEM) || (state == MMUL) || (state == DRAIN);
        done    = (state == FIN);
        err     = (state == FIN) && err_q;
        alu_op  = (state == IDLE) ? 3'b000 : op_q;
    end
endmodule
